// File: rtl/ex_flags_stage_pkg.sv
// Shared definitions for the execute flags stage: flag bit indices, flag
// register width and conditional-jump selector encodings (mirrors lapido_defs.v).
package ex_flags_stage_pkg;

    localparam int unsigned FL_ZERO     = 0;
    localparam int unsigned FL_TRUE     = 1;
    localparam int unsigned FL_NEG      = 2;
    localparam int unsigned FL_OVERFLOW = 3;
    localparam int unsigned FL_NEGZERO  = 4;
    localparam int unsigned FL_CARRY    = 5;

    localparam int unsigned FLAGS_IN_W  = 5;
    localparam int unsigned FLAG_W      = 6;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned COND_SEL_W  = 3;

    typedef enum logic [COND_SEL_W-1:0] {
        COND_ZERO       = 3'd0,
        COND_TRUE       = 3'd1,
        COND_NEG        = 3'd2,
        COND_OVERFLOW   = 3'd3,
        COND_NEGZERO    = 3'd4,
        COND_CARRY      = 3'd5,
        COND_ALWAYS     = 3'd6,
        COND_ALWAYS_ALT = 3'd7
    } cond_sel_e;

endpackage

// File: rtl/ex_flags_stage_cond_eval.sv
// Conditional-jump resolution: picks one architectural flag by cond_sel and
// compares it with the requested jt/jf polarity; selectors 6-7 always take.
module cond_eval
    import ex_flags_stage_pkg::*;
(
    input  logic [FLAG_W-1:0]     flag_reg,
    input  logic [COND_SEL_W-1:0] cond_sel,
    input  logic                  jump_on_true,
    output logic                  taken
);

    logic sel_bit;
    logic always_take;

    always_comb begin
        sel_bit     = 1'b0;
        always_take = 1'b0;
        case (cond_sel_e'(cond_sel))
            COND_ZERO:       sel_bit = flag_reg[FL_ZERO];
            COND_TRUE:       sel_bit = flag_reg[FL_TRUE];
            COND_NEG:        sel_bit = flag_reg[FL_NEG];
            COND_OVERFLOW:   sel_bit = flag_reg[FL_OVERFLOW];
            COND_NEGZERO:    sel_bit = flag_reg[FL_NEGZERO];
            COND_CARRY:      sel_bit = flag_reg[FL_CARRY];
            COND_ALWAYS,
            COND_ALWAYS_ALT: always_take = 1'b1;
            default:         always_take = 1'b1;
        endcase
        taken = always_take | (sel_bit == jump_on_true);
    end

endmodule

// File: rtl/ex_flags_stage.sv
// Execute-stage result register with architectural flag register and
// registered branch resolution. Optional stall counter: EX_STALL_COUNT_EN.
module ex_flags_stage
    import ex_flags_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W:0]       alu_res,
    input  logic [FLAGS_IN_W-1:0] flags,
    input  logic [REG_IDX_W-1:0]  rd,
    input  logic                  reg_write,
    input  logic                  flag_write,
    input  logic                  is_cond_jump,
    input  logic [COND_SEL_W-1:0] cond_sel,
    input  logic                  jump_on_true,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_res,
    output logic [REG_IDX_W-1:0]  out_rd,
    output logic                  out_reg_write,
    output logic [FLAG_W-1:0]     flag_reg,
    output logic                  branch_taken
`ifdef EX_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    logic accept;
    logic held_reg_write;
    logic cond_taken;

    assign in_ready      = !out_valid || out_ready;
    assign accept        = in_valid && in_ready && !flush;
    assign out_reg_write = held_reg_write && out_valid;

    // Evaluated against the pre-edge flag_reg, so a jump never sees its own flag update.
    cond_eval u_cond_eval (
        .flag_reg     (flag_reg),
        .cond_sel     (cond_sel),
        .jump_on_true (jump_on_true),
        .taken        (cond_taken)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_res        <= '0;
            out_rd         <= '0;
            held_reg_write <= 1'b0;
            flag_reg       <= '0;
            branch_taken   <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            branch_taken <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_res        <= alu_res[DATA_W-1:0];
            out_rd         <= rd;
            held_reg_write <= reg_write;
            branch_taken   <= is_cond_jump && cond_taken;
            if (flag_write) begin
                flag_reg <= {alu_res[DATA_W], flags};
            end
        end else begin
            branch_taken <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef EX_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
